hazard_unit_scoreboard: RTL and testbench
=========================================

Name: hazard_unit_scoreboard

Overview:
Parametrised hazard controller for the 5-stage pipeline (F, D, E, M, W). Generalises load-use stalling and M/W forwarding to NUM_SRC source operands, with register-address comparisons performed inside the block. Adds two stateful features:
- an internal PC-write pending tracker, replacing the per-stage PCSrc inputs;
- a busy counter that freezes F/D/E while a multi-cycle execute op (multiply) is in E.

Parameters:
RAW, 4, register address width
NUM_SRC, 3, source operands per instruction (Rn, Rm, Rs)
MUL_LAT, 3, E-stage cycles occupied by a multi-cycle op (>=1)
PC_REG, 15, register index never forwarded (PC)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
SrcAddrD  in  NUM_SRC*RAW  D-stage source addresses, operand i at [i*RAW +: RAW]
SrcValidD  in  NUM_SRC  D-stage source used
SrcAddrE  in  NUM_SRC*RAW  E-stage source addresses
SrcValidE  in  NUM_SRC  E-stage source used
WA3E  in  RAW  E-stage destination
WA3M  in  RAW  M-stage destination
WA3W  in  RAW  W-stage destination
RegWriteE  in  1  E-stage instruction writes a register
RegWriteM  in  1  M-stage instruction writes a register
RegWriteW  in  1  W-stage instruction writes a register
MemtoRegE  in  1  E-stage instruction is a load
PCSrcD  in  1  D-stage instruction writes PC (non-branch)
BranchTakenE  in  1  branch resolved taken in E
MulStartE  in  1  multi-cycle op entered E this cycle
ForwardE  out  2*NUM_SRC  per-source select, 10=M, 01=W, 00=regfile
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register
FlushM  out  1  clear E/M register (bubble)
PCWrPendingF  out  1  PC write in flight

Behaviour:
- Single clock domain. Reset is synchronous and active-high. On reset, clear the internal pend[2:0] (E, M, W) and busy counter cnt. With pend and cnt at 0 and inputs idle, every output is 0.
- Forwarding is combinational and applies per source i.
  - Select 10 if SrcValidE[i], RegWriteM, SrcAddrE_i==WA3M and SrcAddrE_i!=PC_REG.
  - Otherwise select 01 under the same test against the W stage.
  - Otherwise select 00. M has priority over W.
- Load-use stall: LDRStall = MemtoRegE & RegWriteE & (any i: SrcValidD[i] & SrcAddrD_i==WA3E).
- Multi-cycle op:
  - MulBusy = (cnt!=0).
  - On the edge where MulStartE & ~MulBusy & MUL_LAT>1, load cnt <= MUL_LAT-1.
  - While MulBusy, decrement cnt each cycle; it saturates at 0.
  - MUL_LAT=1 means the op is never busy.
  - MulStartE while MulBusy is ignored.
- PC pending tracker:
  - PCWrPendingF = PCSrcD | pend[0] | pend[1] | pend[2].
  - Each edge when ~MulBusy: pend[0] <= PCSrcD & ~LDRStall & ~BranchTakenE; pend[1] <= pend[0]; pend[2] <= pend[1].
  - Each edge when MulBusy: pend[0] holds; pend[1] <= 0; pend[2] <= pend[1].
- Outputs:
  - StallF = LDRStall | PCWrPendingF | MulBusy
  - StallD = LDRStall | MulBusy
  - StallE = MulBusy
  - FlushD = ~MulBusy & ((PCWrPendingF & ~LDRStall) | BranchTakenE)
  - FlushE = ~MulBusy & (LDRStall | BranchTakenE)
  - FlushM = MulBusy
- Simultaneous events:
  - MulBusy overrides all flushes.
  - LDRStall suppresses the PC-pending FlushD so D holds rather than clears.
  - BranchTakenE together with LDRStall gives FlushD=1, FlushE=1, and StallD=1. The flush wins at the pipeline register.
- Reset mid-multiply or mid-PC-write clears the state on the next edge. Outputs then depend only on current inputs.

Test Plan:
- Forwarding: SrcAddrE_0=3, WA3M=3, WA3W=3, both RegWrite=1 -> ForwardE[1:0]=10. Drop RegWriteM -> 01. Set SrcAddrE_0=15 -> 00.
- Load-use: MemtoRegE=1, WA3E=5, SrcAddrD_1=5 valid -> StallF=StallD=FlushE=1 for one cycle. Clear SrcValidD[1] -> all 0.
- PC write: PCSrcD pulse for 1 cycle -> PCWrPendingF=1 for 4 cycles, FlushD=1 for 4 cycles, then 0.
- Multiply, MUL_LAT=3: MulStartE pulse -> StallF=StallD=StallE=FlushM=1 for exactly 2 cycles. A second MulStartE during busy is ignored.
- Collisions: PCSrcD pulse, then MulStartE while pend[0]=1 -> PCWrPendingF extended by 2 cycles, FlushD masked while busy. BranchTakenE pulse -> FlushD=FlushE=1, pend[0]=0.
- Reset mid-op: assert reset while cnt=2 and pend[1]=1 -> next cycle all outputs 0 with idle inputs.

Source files
------------

// File: rtl/hazard_unit_scoreboard.sv
// hazard_unit_scoreboard: pipeline stall/flush/forward control with PC-write and multi-cycle tracking
module hazard_unit_scoreboard #(
  parameter int unsigned RAW     = 4,
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned PC_REG  = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*RAW-1:0]   SrcAddrD,
  input  logic [NUM_SRC-1:0]       SrcValidD,
  input  logic [NUM_SRC*RAW-1:0]   SrcAddrE,
  input  logic [NUM_SRC-1:0]       SrcValidE,
  input  logic [RAW-1:0]           WA3E,
  input  logic [RAW-1:0]           WA3M,
  input  logic [RAW-1:0]           WA3W,
  input  logic                     RegWriteE,
  input  logic                     RegWriteM,
  input  logic                     RegWriteW,
  input  logic                     MemtoRegE,
  input  logic                     PCSrcD,
  input  logic                     BranchTakenE,
  input  logic                     MulStartE,
  output logic [2*NUM_SRC-1:0]     ForwardE,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     StallE,
  output logic                     FlushD,
  output logic                     FlushE,
  output logic                     FlushM,
  output logic                     PCWrPendingF
);
  localparam int unsigned CW = $clog2(MUL_LAT + 1);
  logic [NUM_SRC-1:0] ld_hit;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         pend_q, pend_d;
  logic               ldr_stall, mul_busy;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [RAW-1:0] a;
    logic           fm, fw;
    assign a  = SrcAddrE[i*RAW +: RAW];
    assign fm = SrcValidE[i] & RegWriteM & (a == WA3M) & (a != RAW'(PC_REG));
    assign fw = SrcValidE[i] & RegWriteW & (a == WA3W) & (a != RAW'(PC_REG));
    assign ForwardE[2*i +: 2] = fm ? 2'b10 : fw ? 2'b01 : 2'b00;
    assign ld_hit[i] = SrcValidD[i] & (SrcAddrD[i*RAW +: RAW] == WA3E);
  end
  // MUL_LAT=1 loads zero, so the op never registers as busy
  always_comb begin
    ldr_stall    = MemtoRegE & RegWriteE & |ld_hit;
    mul_busy     = cnt_q != '0;
    cnt_d        = mul_busy ? cnt_q - CW'(1) : MulStartE ? CW'(MUL_LAT - 1) : '0;
    pend_d       = mul_busy ? {pend_q[1], 1'b0, pend_q[0]}
                            : {pend_q[1:0], PCSrcD & ~ldr_stall & ~BranchTakenE};
    PCWrPendingF = PCSrcD | |pend_q;
    StallF       = ldr_stall | PCWrPendingF | mul_busy;
    StallD       = ldr_stall | mul_busy;
    StallE       = mul_busy;
    FlushD       = ~mul_busy & ((PCWrPendingF & ~ldr_stall) | BranchTakenE);
    FlushE       = ~mul_busy & (ldr_stall | BranchTakenE);
    FlushM       = mul_busy;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: tb/tb_hazard_unit_scoreboard.sv
// tb_hazard_unit_scoreboard: table-driven and sequence checks of the hazard controller
module tb_hazard_unit_scoreboard;
  logic        clk = 0, reset;
  logic [11:0] SrcAddrD, SrcAddrE;
  logic [2:0]  SrcValidD, SrcValidE;
  logic [3:0]  WA3E, WA3M, WA3W;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcD, BranchTakenE, MulStartE;
  logic [5:0]  ForwardE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, PCWrPendingF;
  int          n = 0, bad = 0;

  typedef struct {
    logic        rst;
    logic [11:0] sad;
    logic [2:0]  svd;
    logic [11:0] sae;
    logic [2:0]  sve;
    logic [3:0]  wae, wam, waw;
    logic [2:0]  rw;
    logic        mte, pcs, bte, mst;
    logic [5:0]  fwd;
    logic [6:0]  ctl;
  } vec_t;

  vec_t tbl[15];

  hazard_unit_scoreboard dut (
    .clk(clk), .reset(reset),
    .SrcAddrD(SrcAddrD), .SrcValidD(SrcValidD), .SrcAddrE(SrcAddrE), .SrcValidE(SrcValidE),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
    .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .PCWrPendingF(PCWrPendingF)
  );

  always #5 clk = ~clk;

  // ctl bits: StallF StallD StallE FlushD FlushE FlushM PCWrPendingF
  task automatic apply(input vec_t v, input string nm);
    logic [6:0] ctl;
    @(negedge clk);
    reset = v.rst; SrcAddrD = v.sad; SrcValidD = v.svd; SrcAddrE = v.sae; SrcValidE = v.sve;
    WA3E = v.wae; WA3M = v.wam; WA3W = v.waw; {RegWriteE, RegWriteM, RegWriteW} = v.rw;
    MemtoRegE = v.mte; PCSrcD = v.pcs; BranchTakenE = v.bte; MulStartE = v.mst;
    #1;
    ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, PCWrPendingF};
    n++;
    if (ForwardE !== v.fwd || ctl !== v.ctl) begin
      bad++;
      $display("FAIL %s: got fwd=%b ctl=%b, expected fwd=%b ctl=%b", nm, ForwardE, ctl, v.fwd, v.ctl);
    end
  endtask

  task automatic cs(input logic rst, pcs, bte, mst, input logic [6:0] ctl, input string nm);
    apply('{rst, 12'h0, 3'b0, 12'h0, 3'b0, 4'h0, 4'h0, 4'h0, 3'b0, 1'b0, pcs, bte, mst, 6'b0, ctl}, nm);
  endtask

  initial begin
    tbl[0]  = '{0, 12'h000, 3'b000, 12'h000, 3'b000, 4'd0, 4'd0,  4'd0,  3'b000, 0, 0, 0, 0, 6'b000000, 7'b0000000};
    tbl[1]  = '{0, 12'h000, 3'b000, 12'h003, 3'b001, 4'd0, 4'd3,  4'd3,  3'b011, 0, 0, 0, 0, 6'b000010, 7'b0000000};
    tbl[2]  = '{0, 12'h000, 3'b000, 12'h003, 3'b001, 4'd0, 4'd3,  4'd3,  3'b001, 0, 0, 0, 0, 6'b000001, 7'b0000000};
    tbl[3]  = '{0, 12'h000, 3'b000, 12'h00F, 3'b001, 4'd0, 4'd15, 4'd15, 3'b011, 0, 0, 0, 0, 6'b000000, 7'b0000000};
    tbl[4]  = '{0, 12'h000, 3'b000, 12'h793, 3'b111, 4'd0, 4'd9,  4'd7,  3'b011, 0, 0, 0, 0, 6'b011000, 7'b0000000};
    tbl[5]  = '{0, 12'h000, 3'b000, 12'h055, 3'b011, 4'd0, 4'd5,  4'd5,  3'b011, 0, 0, 0, 0, 6'b001010, 7'b0000000};
    tbl[6]  = '{0, 12'h000, 3'b000, 12'h003, 3'b000, 4'd0, 4'd3,  4'd3,  3'b011, 0, 0, 0, 0, 6'b000000, 7'b0000000};
    tbl[7]  = '{0, 12'h050, 3'b010, 12'h000, 3'b000, 4'd5, 4'd0,  4'd0,  3'b100, 1, 0, 0, 0, 6'b000000, 7'b1100100};
    tbl[8]  = '{0, 12'h050, 3'b000, 12'h000, 3'b000, 4'd5, 4'd0,  4'd0,  3'b100, 1, 0, 0, 0, 6'b000000, 7'b0000000};
    tbl[9]  = '{0, 12'h050, 3'b010, 12'h000, 3'b000, 4'd5, 4'd0,  4'd0,  3'b000, 1, 0, 0, 0, 6'b000000, 7'b0000000};
    tbl[10] = '{0, 12'h050, 3'b010, 12'h000, 3'b000, 4'd5, 4'd0,  4'd0,  3'b100, 1, 0, 1, 0, 6'b000000, 7'b1101100};
    tbl[11] = '{0, 12'h050, 3'b010, 12'h000, 3'b000, 4'd5, 4'd0,  4'd0,  3'b100, 1, 1, 0, 0, 6'b000000, 7'b1100101};
    tbl[12] = '{0, 12'h000, 3'b000, 12'h000, 3'b000, 4'd0, 4'd0,  4'd0,  3'b000, 0, 0, 1, 0, 6'b000000, 7'b0001100};
    tbl[13] = '{0, 12'h000, 3'b000, 12'h000, 3'b000, 4'd0, 4'd0,  4'd0,  3'b000, 0, 1, 1, 0, 6'b000000, 7'b1001101};
    tbl[14] = '{0, 12'h500, 3'b100, 12'h000, 3'b000, 4'd5, 4'd0,  4'd0,  3'b100, 1, 0, 0, 0, 6'b000000, 7'b1100100};
    reset = 1; SrcAddrD = 0; SrcValidD = 0; SrcAddrE = 0; SrcValidE = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; PCSrcD = 0; BranchTakenE = 0; MulStartE = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("tbl%0d", i));
    cs(0, 0, 0, 0, 7'b0000000, "idle");
    cs(0, 1, 0, 0, 7'b1001001, "pc0");
    for (int i = 1; i < 4; i++) cs(0, 0, 0, 0, 7'b1001001, $sformatf("pc%0d", i));
    cs(0, 0, 0, 0, 7'b0000000, "pc4");
    cs(0, 0, 0, 1, 7'b0000000, "mul0");
    cs(0, 0, 0, 0, 7'b1110010, "mul1");
    cs(0, 0, 0, 1, 7'b1110010, "mul2_restart");
    cs(0, 0, 0, 0, 7'b0000000, "mul3");
    cs(0, 0, 0, 0, 7'b0000000, "mul4");
    cs(0, 1, 0, 1, 7'b1001001, "colA0");
    cs(0, 0, 0, 0, 7'b1110011, "colA1");
    cs(0, 0, 0, 0, 7'b1110011, "colA2");
    for (int i = 3; i < 6; i++) cs(0, 0, 0, 0, 7'b1001001, $sformatf("colA%0d", i));
    cs(0, 0, 0, 0, 7'b0000000, "colA6");
    cs(0, 1, 0, 0, 7'b1001001, "colB0");
    cs(0, 0, 0, 1, 7'b1001001, "colB1");
    cs(0, 0, 0, 0, 7'b1110011, "colB2");
    cs(0, 0, 0, 0, 7'b1110011, "colB3");
    cs(0, 0, 0, 0, 7'b0000000, "colB4");
    cs(0, 1, 1, 0, 7'b1001101, "br_pc");
    cs(0, 0, 0, 0, 7'b0000000, "br_pc_after");
    cs(0, 0, 0, 1, 7'b0000000, "brmul0");
    cs(0, 0, 1, 0, 7'b1110010, "brmul1_masked");
    cs(0, 0, 0, 0, 7'b1110010, "brmul2");
    cs(0, 0, 0, 0, 7'b0000000, "brmul3");
    cs(0, 1, 0, 0, 7'b1001001, "rst0");
    cs(0, 0, 0, 1, 7'b1001001, "rst1");
    cs(1, 0, 0, 0, 7'b1110011, "rst2_asserted");
    cs(0, 0, 0, 0, 7'b0000000, "rst3_cleared");
    cs(0, 0, 0, 0, 7'b0000000, "rst4_cleared");
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
